// File: rtl/rvc_dmem_arb.sv
// rvc_dmem_arb: arbitrates NUM_CORES core D_MEM ports onto one shared D_MEM port.
// Build option RVC_DMEM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module rvc_dmem_arb #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic                           Clock,
  input  logic                           Rst,
  input  logic [NUM_CORES-1:0]           CoreReqValid,
  input  logic [NUM_CORES-1:0]           CoreWrEn,
  input  logic [NUM_CORES*ADDR_W-1:0]    CoreAddr,
  input  logic [NUM_CORES*DATA_W-1:0]    CoreWrData,
  input  logic [NUM_CORES*DATA_W/8-1:0]  CoreByteEn,
  output logic [NUM_CORES-1:0]           CoreReqReady,
  output logic [NUM_CORES-1:0]           CoreRdValid,
  output logic [DATA_W-1:0]              CoreRdData,
  input  logic                           MemStall,
  output logic                           MemRdEn,
  output logic                           MemWrEn,
  output logic [ADDR_W-1:0]              MemAddr,
  output logic [DATA_W-1:0]              MemWrData,
  output logic [DATA_W/8-1:0]            MemByteEn,
  input  logic [DATA_W-1:0]              MemRdData
);

  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned IDX_W      = $clog2(NUM_CORES);
  localparam int unsigned TAG_STAGES = MEM_LAT + 1;

  logic              w_grant;
  logic [IDX_W-1:0]  w_win;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [BE_W-1:0]   w_sel_be;
  logic              w_rd_accept;

  logic              r_MemRdEn;
  logic              r_MemWrEn;
  logic [ADDR_W-1:0] r_MemAddr;
  logic [DATA_W-1:0] r_MemWrData;
  logic [BE_W-1:0]   r_MemByteEn;

  logic [TAG_STAGES-1:0] r_TagVld;
  logic [IDX_W-1:0]      r_TagIdx [TAG_STAGES];

`ifdef RVC_DMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_grant = 1'b0;
    w_win   = '0;
    if (!MemStall) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (!w_grant && CoreReqValid[i]) begin
          w_grant = 1'b1;
          w_win   = IDX_W'(i);
        end
      end
    end
  end
`else
  logic [IDX_W-1:0] r_RrPtr;

  // Search order starts at r_RrPtr and wraps modulo NUM_CORES (not necessarily a power of two).
  always_comb begin
    int unsigned v_idx;
    w_grant = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    if (!MemStall) begin
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
        v_idx = 32'(r_RrPtr) + j;
        if (v_idx >= NUM_CORES) begin
          v_idx = v_idx - NUM_CORES;
        end
        if (!w_grant && CoreReqValid[v_idx]) begin
          w_grant = 1'b1;
          w_win   = IDX_W'(v_idx);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      r_RrPtr <= '0;
    end else if (w_grant) begin
      if (w_win == IDX_W'(NUM_CORES - 1)) begin
        r_RrPtr <= '0;
      end else begin
        r_RrPtr <= w_win + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_sel_wr    = CoreWrEn[i];
        w_sel_addr  = CoreAddr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = CoreWrData[i*DATA_W +: DATA_W];
        w_sel_be    = CoreByteEn[i*BE_W +: BE_W];
      end
    end
  end

  always_comb begin
    CoreReqReady = '0;
    if (w_grant) begin
      CoreReqReady[w_win] = 1'b1;
    end
  end

  assign w_rd_accept = w_grant & ~w_sel_wr;

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      r_MemRdEn   <= 1'b0;
      r_MemWrEn   <= 1'b0;
      r_MemAddr   <= '0;
      r_MemWrData <= '0;
      r_MemByteEn <= '0;
    end else begin
      r_MemRdEn <= w_rd_accept;
      r_MemWrEn <= w_grant & w_sel_wr;
      if (w_grant) begin
        r_MemAddr   <= w_sel_addr;
        r_MemWrData <= w_sel_wdata;
        r_MemByteEn <= w_sel_be;
      end
    end
  end

  // Stage 0 is loaded alongside the command; the last stage lines up with MemRdData.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      r_TagVld <= '0;
      for (int unsigned s = 0; s < TAG_STAGES; s++) begin
        r_TagIdx[s] <= '0;
      end
    end else begin
      r_TagVld    <= {r_TagVld[TAG_STAGES-2:0], w_rd_accept};
      r_TagIdx[0] <= w_win;
      for (int unsigned s = 1; s < TAG_STAGES; s++) begin
        r_TagIdx[s] <= r_TagIdx[s-1];
      end
    end
  end

  always_comb begin
    CoreRdValid = '0;
    if (r_TagVld[TAG_STAGES-1]) begin
      CoreRdValid[r_TagIdx[TAG_STAGES-1]] = 1'b1;
    end
  end

  assign CoreRdData = MemRdData;
  assign MemRdEn    = r_MemRdEn;
  assign MemWrEn    = r_MemWrEn;
  assign MemAddr    = r_MemAddr;
  assign MemWrData  = r_MemWrData;
  assign MemByteEn  = r_MemByteEn;

endmodule
